// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: FSM state encoding and the
// counter value every entry returns to (weakly not-taken).
package rv32i_types;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } bp_state_t;

   localparam logic [1:0] BP_CTR_INIT = 2'b01;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-value logic for one predictor entry.
// restart_i restores the weakly-not-taken value before the update is
// applied, so a newly allocated branch starts from a neutral count.
module sat_counter2
   import rv32i_types::*;
(
   input  logic [1:0] ctr_i,
   input  logic       restart_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   logic [1:0] base;

   // Select the starting count, then step it toward taken/not-taken with saturation.
   always_comb begin
      base  = restart_i ? BP_CTR_INIT : ctr_i;
      ctr_o = base;
      if (taken_i) begin
         if (base != 2'b11) ctr_o = base + 2'd1;
      end else begin
         if (base != 2'b00) ctr_o = base - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counters plus tagged target table.
// After reset an INIT sweep clears one entry per cycle; lookups respond one
// cycle after the request and read the table before same-cycle updates.
// Optional macro BP_GSHARE_EN: counters are indexed by PC index XOR a
// global history of resolved directions; tag/target stay PC-indexed.
module branch_predictor
   import rv32i_types::*;
#(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned TAG_BITS   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ready,
   input  logic        pred_req,
   input  logic [31:0] pred_pc,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam int unsigned TAG_LO  = INDEX_BITS + 2;
   localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

   bp_state_t             state_q, state_d;
   logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
   logic                  init_we;

   logic [1:0]            ctr_q   [ENTRIES];
   logic [1:0]            ctr_d   [ENTRIES];
   logic                  valid_q [ENTRIES];
   logic                  valid_d [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
   logic [TAG_BITS-1:0]   tag_d   [ENTRIES];
   logic [31:0]           tgt_q   [ENTRIES];
   logic [31:0]           tgt_d   [ENTRIES];

   logic                  pred_valid_q, pred_valid_d;
   logic                  pred_taken_q, pred_taken_d;
   logic [31:0]           pred_target_q, pred_target_d;

`ifdef BP_GSHARE_EN
   logic [INDEX_BITS-1:0] hist_q, hist_d;
`endif

   logic [INDEX_BITS-1:0] lk_pidx, lk_cidx, up_pidx, up_cidx;
   logic [TAG_BITS-1:0]   lk_tag, up_tag;
   logic                  lk_accept, up_accept, up_hit;
   logic [1:0]            up_ctr_cur, up_ctr_next;
   logic                  unused_ok;

   // Split PCs into table index and tag; pick the counter index.
   always_comb begin
      lk_pidx = pred_pc[TAG_LO-1:2];
      lk_tag  = pred_pc[TAG_HI:TAG_LO];
      up_pidx = upd_pc[TAG_LO-1:2];
      up_tag  = upd_pc[TAG_HI:TAG_LO];
`ifdef BP_GSHARE_EN
      lk_cidx = lk_pidx ^ hist_q;
      up_cidx = up_pidx ^ hist_q;
`else
      lk_cidx = lk_pidx;
      up_cidx = up_pidx;
`endif
      unused_ok = ^{pred_pc[31:TAG_HI+1], pred_pc[1:0],
                    upd_pc[31:TAG_HI+1], upd_pc[1:0]};
   end

   // INIT/READY sequencing and the init sweep pointer.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      init_we    = 1'b0;
      ready      = (state_q == READY);
      case (state_q)
         INIT: begin
            init_we    = 1'b1;
            init_idx_d = init_idx_q + INDEX_BITS'(1);
            if (init_idx_q == '1) state_d = READY;
         end
         READY: ;
         default: state_d = INIT;
      endcase
      lk_accept = pred_req  && (state_q == READY);
      up_accept = upd_valid && (state_q == READY);
   end

   // Current counter for the resolving branch and whether it owns the entry.
   always_comb begin
      up_ctr_cur = ctr_q[up_cidx];
      up_hit     = valid_q[up_pidx] && (tag_q[up_pidx] == up_tag);
   end

   sat_counter2 u_sat (
      .ctr_i     (up_ctr_cur),
      .restart_i (!up_hit),
      .taken_i   (upd_taken),
      .ctr_o     (up_ctr_next)
   );

   // Next table contents: init sweep write, or a resolved-branch update.
   always_comb begin
      ctr_d   = ctr_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      if (init_we) begin
         ctr_d[init_idx_q]   = BP_CTR_INIT;
         valid_d[init_idx_q] = 1'b0;
      end
      if (up_accept) begin
         ctr_d[up_cidx] = up_ctr_next;
         if (upd_taken) begin
            valid_d[up_pidx] = 1'b1;
            tag_d[up_pidx]   = up_tag;
            tgt_d[up_pidx]   = upd_target;
         end
      end
   end

   // Lookup response built from the pre-update table contents.
   always_comb begin
      pred_valid_d  = lk_accept;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      if (lk_accept && ctr_q[lk_cidx][1] && valid_q[lk_pidx] &&
          (tag_q[lk_pidx] == lk_tag)) begin
         pred_taken_d  = 1'b1;
         pred_target_d = tgt_q[lk_pidx];
      end
`ifdef BP_GSHARE_EN
      hist_d = hist_q;
      if (up_accept) hist_d = {hist_q[INDEX_BITS-2:0], upd_taken};
`endif
   end

   // Control and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= INIT;
         init_idx_q    <= '0;
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
`ifdef BP_GSHARE_EN
         hist_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         init_idx_q    <= init_idx_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
`ifdef BP_GSHARE_EN
         hist_q        <= hist_d;
`endif
      end
   end

   // Table storage; cleared by the INIT sweep rather than by reset.
   always_ff @(posedge clk) begin
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
   end

   // Drive response outputs from their registers.
   always_comb begin
      pred_valid  = pred_valid_q;
      pred_taken  = pred_taken_q;
      pred_target = pred_target_q;
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized phase, compared against a behavioural table model.
module tb_branch_predictor;

   localparam int unsigned IB      = 6;
   localparam int unsigned TBITS   = 8;
   localparam int unsigned ENTRIES = 64;

   logic        clk = 1'b0;
   logic        rst_n, ready;
   logic        pred_req, pred_valid, pred_taken;
   logic [31:0] pred_pc, pred_target;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc, upd_target;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int          m_ctr  [ENTRIES];
   bit          m_val  [ENTRIES];
   int unsigned m_tag  [ENTRIES];
   logic [31:0] m_tgt  [ENTRIES];
   int unsigned m_hist;
   int unsigned m_init_left;

   always #5 clk = ~clk;

   branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TBITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ready       (ready),
      .pred_req    (pred_req),
      .pred_pc     (pred_pc),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target)
   );

   function automatic int unsigned idx_of(logic [31:0] pc);
      return (pc >> 2) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(logic [31:0] pc);
      return (pc >> (IB + 2)) % (1 << TBITS);
   endfunction

   function automatic int unsigned slot_of(logic [31:0] pc);
`ifdef BP_GSHARE_EN
      return idx_of(pc) ^ m_hist;
`else
      return idx_of(pc);
`endif
   endfunction

   function automatic logic [31:0] pool_pc();
      logic [31:0] pc;
      pc       = $urandom;
      pc[7:2]  = 6'($urandom_range(0, 7));
      pc[15:8] = 8'($urandom_range(0, 1));
      return pc;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_ctr[i] = 1;
         m_val[i] = 1'b0;
      end
      m_hist      = 0;
      m_init_left = ENTRIES;
   endtask

   // One clock: predict from the model, advance, compare all outputs.
   task automatic tick();
      bit          e_ready, e_valid, e_taken;
      logic [31:0] e_tgt;
      int unsigned p, c;
      e_valid = 1'b0;
      e_taken = 1'b0;
      e_tgt   = '0;
      if (!rst_n) begin
         model_reset();
         e_ready = 1'b0;
      end else if (m_init_left > 0) begin
         m_init_left--;
         e_ready = (m_init_left == 0);
      end else begin
         e_ready = 1'b1;
         if (pred_req) begin
            p       = idx_of(pred_pc);
            c       = slot_of(pred_pc);
            e_valid = 1'b1;
            if (m_ctr[c] >= 2 && m_val[p] && m_tag[p] == tag_of(pred_pc)) begin
               e_taken = 1'b1;
               e_tgt   = m_tgt[p];
            end
         end
         if (upd_valid) begin
            p = idx_of(upd_pc);
            c = slot_of(upd_pc);
            if (!(m_val[p] && m_tag[p] == tag_of(upd_pc))) m_ctr[c] = 1;
            m_ctr[c] = upd_taken ? ((m_ctr[c] + 1 > 3) ? 3 : m_ctr[c] + 1)
                                 : ((m_ctr[c] - 1 < 0) ? 0 : m_ctr[c] - 1);
            if (upd_taken) begin
               m_val[p] = 1'b1;
               m_tag[p] = tag_of(upd_pc);
               m_tgt[p] = upd_target;
            end
            m_hist = ((m_hist << 1) | (upd_taken ? 1 : 0)) % ENTRIES;
         end
      end
      @(posedge clk);
      #1;
      chk("ready", ready, e_ready);
      chk("pred_valid", pred_valid, e_valid);
      chk("pred_taken", pred_taken, e_taken);
      chk("pred_target", pred_target, e_tgt);
   endtask

   task automatic idle();
      pred_req   = 1'b0;
      pred_pc    = '0;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_target = '0;
   endtask

   task automatic rand_inputs();
      pred_req   = 1'($urandom_range(0, 1));
      pred_pc    = pool_pc();
      upd_valid  = 1'($urandom_range(0, 1));
      upd_pc     = pool_pc();
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      idle();
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      tick();
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      idle();
      pred_req = 1'b1; pred_pc = pc;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();

      // Reset held two cycles with ignored traffic on the inputs.
      repeat (2) begin
         rand_inputs();
         tick();
      end
      chk("ready_in_reset", ready, 1'b0);

      // INIT sweep: requests ignored, ready rises after exactly 64 cycles.
      rst_n = 1'b1;
      repeat (ENTRIES - 1) begin
         rand_inputs();
         tick();
      end
      chk("ready_before_last_init", ready, 1'b0);
      rand_inputs();
      tick();
      chk("ready_after_init", ready, 1'b1);

      // Freshly cleared table never predicts taken.
      repeat (8) begin
         do_lookup($urandom);
         chk("cold_lookup_taken", pred_taken, 1'b0);
      end

      // Training at 0x60.
      do_upd(32'h60, 1'b1, 32'h100);
      do_upd(32'h60, 1'b1, 32'h100);
      do_lookup(32'h60);
`ifndef BP_GSHARE_EN
      chk("train_valid", pred_valid, 1'b1);
      chk("train_taken", pred_taken, 1'b1);
      chk("train_target", pred_target, 32'h100);
`endif

      // Saturation at 00 after five not-taken updates.
      repeat (5) do_upd(32'h60, 1'b0, 32'h0);
      do_lookup(32'h60);
`ifndef BP_GSHARE_EN
      chk("sat_taken", pred_taken, 1'b0);
      chk("sat_target", pred_target, 32'h0);
`endif

      // Collision: same index, different tag.
      do_upd(32'h60, 1'b1, 32'h100);
      do_upd(32'h60, 1'b1, 32'h100);
      do_lookup(32'h160);
`ifndef BP_GSHARE_EN
      chk("collision_taken", pred_taken, 1'b0);
`endif

      // Same-cycle lookup and taken update at 0x80: pre-update entry returned.
      idle();
      pred_req = 1'b1; pred_pc = 32'h80;
      upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h200;
      tick();
`ifndef BP_GSHARE_EN
      chk("same_cycle_taken", pred_taken, 1'b0);
`endif
      do_lookup(32'h80);
`ifndef BP_GSHARE_EN
      chk("after_same_cycle_taken", pred_taken, 1'b1);
      chk("after_same_cycle_target", pred_target, 32'h200);
`endif

      // Randomized concurrent lookups and updates.
      repeat (400) begin
         rand_inputs();
         tick();
      end

      // Reset during a lookup: no response, full sweep again.
      idle();
      pred_req = 1'b1; pred_pc = 32'h60;
      rst_n = 1'b0;
      tick();
      chk("midreset_no_valid", pred_valid, 1'b0);
      rst_n = 1'b1;
      repeat (ENTRIES) begin
         rand_inputs();
         tick();
      end
      chk("midreset_ready", ready, 1'b1);
      do_lookup(32'h60);
      chk("midreset_cleared_taken", pred_taken, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, meaning log2 of table entries (64).
REQ-002 SHALL have parameter TAG_BITS, default 8, meaning the width of the PC tag stored per target entry.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port ready, output, 1 bit: the table is initialised and accepts requests.
REQ-006 SHALL have port pred_req, input, 1 bit: fetch lookup request.
REQ-007 SHALL have port pred_pc, input, 32 bits: fetch PC.
REQ-008 SHALL have port pred_valid, output, 1 bit: the prediction response is valid.
REQ-009 SHALL have port pred_taken, output, 1 bit: predicted branch direction.
REQ-010 SHALL have port pred_target, output, 32 bits: predicted target; 0 when not taken.
REQ-011 SHALL have port upd_valid, input, 1 bit: a resolved branch from execute.
REQ-012 SHALL have port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-013 SHALL have port upd_taken, input, 1 bit: resolved br_en from the comparator.
REQ-014 SHALL have port upd_target, input, 32 bits: resolved branch target.

Function
REQ-015 SHALL index the table with pc[INDEX_BITS+1:2] and tag it with pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
REQ-016 SHALL store per entry a 2-bit saturating counter, a valid bit, a tag and a 32-bit target.
REQ-017 SHALL implement an FSM with states INIT and READY; reset enters INIT with index 0.
REQ-018 SHALL, in INIT, write one entry per cycle (counter=01, valid=0), advance the index, and enter READY after writing entry 2^INDEX_BITS-1, so INIT lasts 2^INDEX_BITS cycles.
REQ-019 SHALL drive ready=1 only in READY, and SHALL ignore pred_req and upd_valid while in INIT.
REQ-020 SHALL respond one cycle after an accepted pred_req: pred_valid=1 for exactly that cycle.
REQ-021 SHALL set pred_taken=1 only when counter[1]=1, valid=1 and the tag matches; otherwise pred_taken=0 and pred_target=0.
REQ-022 SHALL, on upd_valid, increment the counter on upd_taken=1 (saturating at 11) and decrement it on upd_taken=0 (saturating at 00).
REQ-023 SHALL, on upd_valid with upd_taken=1, write the tag and target and set valid=1.
REQ-024 SHALL, on upd_valid with a tag mismatch, reset the counter to 01 before applying the update.
REQ-025 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update entry (read-before-write).
REQ-026 SHALL accept lookups and updates to different indices concurrently, one of each per cycle, with no stall.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, set FSM=INIT, init index=0, ready=0, pred_valid=0, pred_taken=0 and pred_target=0.
REQ-028 SHALL, on reset mid-operation, discard any in-flight response and rerun the full INIT sweep.

Configuration
REQ-029 SHALL support the macro BP_GSHARE_EN.
REQ-030 SHALL, with BP_GSHARE_EN defined, keep an INDEX_BITS-wide global history register that is reset to 0 and shifts in upd_taken on each upd_valid.
REQ-031 SHALL, with BP_GSHARE_EN defined, index the counters with the PC index XOR the history; the target and tag arrays remain PC-indexed.
REQ-032 SHALL, without BP_GSHARE_EN, use pure PC indexing and contain no history register.

Structure
REQ-033 SHALL define bp_state_t (INIT, READY) and the counter reset constant 2'b01 in rv32i_types.
REQ-034 SHALL place the counter saturation logic in one sub-module, sat_counter2.

Verification
REQ-035 Reset scenario: hold rst_n=0 for 2 cycles, then release -> ready=0 for 64 cycles, then ready=1; every lookup afterwards returns pred_taken=0.
REQ-036 Training scenario: two updates at pc=0x60 with upd_taken=1 and upd_target=0x100, then lookup 0x60 -> next cycle pred_valid=1, pred_taken=1, pred_target=0x100.
REQ-037 Saturation scenario: four not-taken updates at 0x60 after the training scenario -> counter=00; a fifth update leaves it at 00; lookup -> pred_taken=0.
REQ-038 Collision scenario: train 0x60, then lookup 0x160 (same index, different tag) -> pred_taken=0.
REQ-039 Same-cycle scenario: counter=01 at 0x80, then a same-cycle lookup and taken update at 0x80 -> response pred_taken=0; an immediately following lookup -> pred_taken=1.
REQ-040 Mid-operation reset scenario: assert rst_n=0 during a lookup -> no pred_valid pulse, ready=0 and a full INIT sweep.
